// File: rtl/systolic_skew_feeder.sv
// Input FIFO plus diagonal skew stage feeding multi_mode_buffer.input_data.
// Lane i of each popped vector appears i+1 cycles after the pop; a tile's last vector triggers a drain and done.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH        = 8,
    parameter int NUMBER_OF_BUFFERS = 4,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [DATA_WIDTH*NUMBER_OF_BUFFERS-1:0] in_data,
    input  logic                                    in_valid,
    input  logic                                    in_last,
    output logic                                    in_ready,
    output logic [DATA_WIDTH*NUMBER_OF_BUFFERS-1:0] out_data,
    output logic [NUMBER_OF_BUFFERS-1:0]            out_lane_valid,
    output logic                                    busy,
    output logic                                    done
);
    localparam int N  = NUMBER_OF_BUFFERS;
    localparam int DW = DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(N + 1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef struct packed {
        logic              last;
        logic [N*DW-1:0]   data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    entry_t        mem_q [FIFO_DEPTH];
    entry_t        mem_d [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full, empty, push, pop;
    entry_t        head;
    logic [N-1:0][DW-1:0] lane_in;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = !empty && (state_q != DRAIN);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign busy     = (state_q != IDLE);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = '{last: in_last, data: in_data};
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        case (state_q)
            IDLE, STREAM: begin
                if (pop) begin
                    if (head.last) begin
                        state_d = DRAIN;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            DRAIN: begin
                cnt_d = cnt_q - CNT_ONE;
                // Counter hits 1 exactly when lane N-1 of the last vector is on out_data.
                if (cnt_q == CNT_ONE) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Cycles without a pop inject a zero/invalid bubble that skews like real data.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            lane_in[i] = pop ? head.data[i*DW +: DW] : '0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [i:0][DW-1:0] data_q, data_d;
        logic [i:0]         vld_pipe_q, vld_pipe_d;

        always_comb begin
            data_d        = data_q;
            vld_pipe_d    = vld_pipe_q;
            data_d[0]     = lane_in[i];
            vld_pipe_d[0] = pop;
            for (int k = 1; k <= i; k++) begin
                data_d[k]     = data_q[k-1];
                vld_pipe_d[k] = vld_pipe_q[k-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q     <= '0;
                vld_pipe_q <= '0;
            end else begin
                data_q     <= data_d;
                vld_pipe_q <= vld_pipe_d;
            end
        end

        assign out_data[i*DW +: DW] = data_q[i];
        assign out_lane_valid[i]    = vld_pipe_q[i];
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: table of per-cycle vectors plus
// hand sequences for FIFO-full backpressure and reset during drain.
module tb_systolic_skew_feeder;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int W  = DW * N;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid, in_last, in_ready;
    logic [W-1:0] out_data;
    logic [N-1:0] out_lane_valid;
    logic         busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    systolic_skew_feeder #(
        .DATA_WIDTH(DW), .NUMBER_OF_BUFFERS(N), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_lane_valid(out_lane_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        last;
        logic [31:0] din;
        logic [31:0] e_data;
        logic [3:0]  e_lv;
        logic        e_done;
        logic        e_busy;
        logic        e_rdy;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(input logic v, input logic l, input logic [31:0] d,
                                input logic [31:0] ed, input logic [3:0] elv,
                                input logic edn, input logic eb, input logic er);
        row_t r;
        r.vld = v; r.last = l; r.din = d;
        r.e_data = ed; r.e_lv = elv; r.e_done = edn; r.e_busy = eb; r.e_rdy = er;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic l, input logic [31:0] d);
        in_valid = v;
        in_last  = l;
        in_data  = d;
    endtask

    task automatic run_rows(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            drive(tbl[i].vld, tbl[i].last, tbl[i].din);
            @(negedge clk);
            chk($sformatf("%s_row%0d", tag, i),
                {25'b0, out_data, out_lane_valid, done, busy, in_ready},
                {25'b0, tbl[i].e_data, tbl[i].e_lv, tbl[i].e_done, tbl[i].e_busy, tbl[i].e_rdy});
            tick();
        end
    endtask

    initial begin
        // rows 0-6: single-vector tile
        tbl.push_back(mk(1, 1, 32'h04030201, 32'h00000000, 4'b0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'h00000000, 4'b0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'h00000001, 4'b0001, 0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'h00000200, 4'b0010, 0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'h00030000, 4'b0100, 0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'h04000000, 4'b1000, 1, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'h00000000, 4'b0000, 0, 0, 1));
        // rows 7-15: back-to-back three-vector tile
        tbl.push_back(mk(1, 0, 32'h10101010, 32'h00000000, 4'b0000, 0, 0, 1));
        tbl.push_back(mk(1, 0, 32'h20202020, 32'h00000000, 4'b0000, 0, 0, 1));
        tbl.push_back(mk(1, 1, 32'h30303030, 32'h00000010, 4'b0001, 0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'h00001020, 4'b0011, 0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'h00102030, 4'b0111, 0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'h10203000, 4'b1110, 0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'h20300000, 4'b1100, 0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'h30000000, 4'b1000, 1, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'h00000000, 4'b0000, 0, 0, 1));
        // rows 16-24: vector A, bubble, vector B (last)
        tbl.push_back(mk(1, 0, 32'hA3A2A1A0, 32'h00000000, 4'b0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'h00000000, 4'b0000, 0, 0, 1));
        tbl.push_back(mk(1, 1, 32'hB3B2B1B0, 32'h000000A0, 4'b0001, 0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'h0000A100, 4'b0010, 0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'h00A200B0, 4'b0101, 0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'hA300B100, 4'b1010, 0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'h00B20000, 4'b0100, 0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'hB3000000, 4'b1000, 1, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        32'h00000000, 4'b0000, 0, 0, 1));

        // Reset asserted between edges must clear outputs immediately.
        rst = 1'b0;
        drive(0, 0, '0);
        #2 rst = 1'b1;
        #1;
        chk("reset_outputs", {25'b0, out_data, out_lane_valid, done, busy, in_ready},
            {25'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1});
        @(posedge clk);
        tick();
        rst = 1'b0;

        run_rows(0, 24, "tbl");

        // FIFO fills while the prior tile drains; accepts resume after the first post-done pop.
        begin
            int k;
            logic       ev;
            logic [7:0] ed;
            k = 0;
            drive(1, 1, {4{8'h01}});
            tick();
            drive(0, 0, '0);
            tick();
            for (int c = 2; c <= 15; c++) begin
                drive(k < 6, k == 5, {4{8'(8'h40 + k)}});
                @(negedge clk);
                if (c <= 8)
                    chk($sformatf("full_rdy_c%0d", c), {63'b0, in_ready}, {63'b0, (c != 6)});
                chk($sformatf("full_done_c%0d", c), {63'b0, done}, {63'b0, (c == 5 || c == 15)});
                ev = (c == 2) || (c >= 7 && c <= 12);
                ed = (c == 2) ? 8'h01 : (ev ? 8'(8'h40 + c - 7) : 8'h00);
                chk($sformatf("full_lane0_c%0d", c), {55'b0, out_lane_valid[0], out_data[7:0]},
                    {55'b0, ev, ed});
                if (in_valid && in_ready) k++;
                tick();
            end
            drive(0, 0, '0);
            chk("full_accepted", 64'(k), 64'd6);
            @(negedge clk);
            chk("full_idle_after", {62'b0, busy, in_ready}, {62'b0, 1'b0, 1'b1});
            tick();
        end

        // Reset one cycle before done: no done, FIFO contents discarded, fresh tile works.
        begin
            drive(1, 1, 32'h04030201);
            tick();
            drive(0, 0, '0);
            tick();
            drive(1, 1, 32'hDEADBEEF);
            @(negedge clk);
            chk("rd_lane0_c2", {55'b0, out_lane_valid[0], out_data[7:0]}, {55'b0, 1'b1, 8'h01});
            tick();
            drive(0, 0, '0);
            tick();
            rst = 1'b1;
            #1;
            chk("rd_async_clear", {25'b0, out_data, out_lane_valid, done, busy, in_ready},
                {25'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1});
            @(negedge clk);
            @(posedge clk);
            @(negedge clk);
            chk("rd_no_done", {63'b0, done}, 64'd0);
            tick();
            rst = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                chk($sformatf("rd_flushed_c%0d", c), {59'b0, out_lane_valid, busy}, 64'd0);
                tick();
            end
            run_rows(0, 6, "post_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
